// File: rtl/spi_slave.sv
// SPI slave: synchronised pins, all four modes, one-word tx buffer.
// Bus-clocked design; SCLK phases must span at least 3 clk periods.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e state_q;

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic mosi_s1_q, mosi_s2_q, mosi_s3_q;

  logic [1:0]            flush_q;
  logic                  armed_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] rx_sh_q;
  logic [DATA_WIDTH-1:0] txbuf_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  txfull_q;
  logic                  rx_valid_q;
  logic                  underrun_q;
  logic                  pend_q;

  logic                  lead;
  logic                  trail;
  logic                  sample;
  logic                  shift_en;
  logic                  cs_fall;
  logic                  cs_rise;
  logic                  last;
  logic                  word_start;
  logic                  first_lead;
  logic [DATA_WIDTH-1:0] rx_word_d;
  logic [DATA_WIDTH-1:0] load_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1_q <= cpol;
      sclk_s2_q <= cpol;
      sclk_s3_q <= cpol;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      mosi_s3_q <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      cs_s1_q   <= cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
      mosi_s3_q <= mosi_s2_q;
    end
  end

  assign lead     = (sclk_s3_q == cpol) && (sclk_s2_q != cpol);
  assign trail    = (sclk_s3_q != cpol) && (sclk_s2_q == cpol);
  assign sample   = cpha ? trail : lead;
  assign shift_en = cpha ? lead : trail;
  // Reset preloads cs_n=1; a low pin must not look like a fresh select.
  assign cs_fall  = armed_q && cs_s3_q && !cs_s2_q;
  assign cs_rise  = !cs_s3_q && cs_s2_q;
  assign last     = (cnt_q == LAST);

  assign rx_word_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_s3_q};
  assign load_d    = txfull_q ? txbuf_q : '0;

  assign word_start =
    ((state_q == IDLE) && cs_fall) ||
    ((state_q == ACTIVE) && !cs_rise && sample && last);

  assign first_lead =
    (state_q == ACTIVE) && !cs_rise && lead && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      flush_q    <= '0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_sh_q    <= '0;
      txbuf_q    <= '0;
      txfull_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (flush_q != 2'd3) begin
        flush_q <= flush_q + 2'd1;
      end else if (cs_s3_q) begin
        armed_q <= 1'b1;
      end
      if (tx_valid && !txfull_q) begin
        txbuf_q  <= tx_data;
        txfull_q <= 1'b1;
      end
      // An empty word counts only once the master starts clocking it.
      underrun_q <= (underrun_q && !underrun_clr) ||
                    (first_lead && pend_q);
      if (first_lead) begin
        pend_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rx_sh_q <= '0;
            pend_q  <= 1'b0;
          end else if (sample) begin
            rx_sh_q <= rx_word_d;
            if (last) begin
              cnt_q      <= '0;
              rx_data_q  <= rx_word_d;
              rx_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (shift_en && (cnt_q != '0)) begin
            shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
      if (word_start) begin
        shift_q <= load_d;
        if (txfull_q) begin
          txfull_q <= 1'b0;
        end else begin
          pend_q <= 1'b1;
        end
      end
    end
  end

  assign miso     = (state_q == ACTIVE) && shift_q[DATA_WIDTH-1];
  assign miso_oe  = (state_q == ACTIVE);
  assign tx_ready = !txfull_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;

endmodule
